// File: rtl/demux_1to2_buffered.sv
// Buffered 1-to-2 result router: one producer stream steered
// into two independent 2-entry FIFO branches with valid/ready.

module demux_branch_fifo #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [size-1:0] data_i,
  input  logic            ready_i,
  output logic            full_o,
  output logic            valid_o,
  output logic [size-1:0] data_o,
  output logic [7:0]      cnt_o
);

  logic [size-1:0] mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      occ;
  logic [7:0]      cnt;
  logic            pop;

  assign valid_o = (occ != 2'd0);
  assign full_o  = (occ == 2'd2);
  assign data_o  = mem[rd_ptr];
  assign cnt_o   = cnt;
  assign pop     = valid_o && ready_i;

  // push is pre-gated by !full, pop by !empty
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
      cnt    <= 8'd0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ~wr_ptr;
        cnt         <= cnt + 8'd1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_i, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

module demux_1to2_buffered #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic            valid0_o,
  input  logic            ready0_i,
  output logic [size-1:0] data1_o,
  output logic            valid1_o,
  input  logic            ready1_i,
  output logic [7:0]      cnt0_o,
  output logic [7:0]      cnt1_o
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  assign ready_o = select_i ? !full1 : !full0;
  assign push0   = valid_i && ready_o && !select_i;
  assign push1   = valid_i && ready_o && select_i;

  demux_branch_fifo #(.size(size)) u_br0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push0),
    .data_i  (data_i),
    .ready_i (ready0_i),
    .full_o  (full0),
    .valid_o (valid0_o),
    .data_o  (data0_o),
    .cnt_o   (cnt0_o)
  );

  demux_branch_fifo #(.size(size)) u_br1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push1),
    .data_i  (data_i),
    .ready_i (ready1_i),
    .full_o  (full1),
    .valid_o (valid1_o),
    .data_o  (data1_o),
    .cnt_o   (cnt1_o)
  );

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Self-checking bench for demux_1to2_buffered:
// directed scenarios plus random traffic against a queue model.

module tb_demux_1to2_buffered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_i;
  logic        select_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data0_o;
  logic        valid0_o;
  logic        ready0_i;
  logic [31:0] data1_o;
  logic        valid1_o;
  logic        ready1_i;
  logic [7:0]  cnt0_o;
  logic [7:0]  cnt1_o;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          acc0;
  int          acc1;
  int          n_checks;
  int          n_fails;

  always #5 clk = ~clk;

  demux_1to2_buffered #(.size(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .cnt0_o   (cnt0_o),
    .cnt1_o   (cnt1_o)
  );

  // Model: each branch is a queue of at most 2 words
  task automatic tick();
    bit p0, p1, o0, o1;
    p0 = valid_i && !select_i && (q0.size() < 2);
    p1 = valid_i && select_i && (q1.size() < 2);
    o0 = (q0.size() > 0) && ready0_i;
    o1 = (q1.size() > 0) && ready1_i;
    @(posedge clk);
    #1;
    if (o0) void'(q0.pop_front());
    if (o1) void'(q1.pop_front());
    if (p0) begin q0.push_back(data_i); acc0++; end
    if (p1) begin q1.push_back(data_i); acc1++; end
  endtask

  task automatic hw_reset();
    rst_n = 1'b0;
    #2;
    q0.delete();
    q1.delete();
    acc0 = 0;
    acc1 = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (valid0_o !== 1'b0 || valid1_o !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_valid got %b%b exp 00", valid0_o, valid1_o);
    end
    n_checks++;
    if (ready_o !== 1'b1 || cnt0_o !== 8'd0 || cnt1_o !== 8'd0) begin
      n_fails++;
      $display("FAIL reset_rdy_cnt got %b %0d %0d exp 1 0 0",
               ready_o, cnt0_o, cnt1_o);
    end
    n_checks++;
    if (data0_o !== 32'd0 || data1_o !== 32'd0) begin
      n_fails++;
      $display("FAIL reset_data got %h %h exp 0 0", data0_o, data1_o);
    end
    rst_n = 1'b1;
    tick();
    // fill branch 0, then reset mid-run without a clock edge
    ready0_i = 1'b0; select_i = 1'b0; valid_i = 1'b1;
    data_i = 32'h5a5a_0001; tick();
    data_i = 32'h5a5a_0002; tick();
    valid_i = 1'b0;
    #1;
    n_checks++;
    if (valid0_o !== 1'b1 || cnt0_o !== 8'd2 || ready_o !== 1'b0) begin
      n_fails++;
      $display("FAIL prefill got v=%b c=%0d r=%b exp 1 2 0",
               valid0_o, cnt0_o, ready_o);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid0_o !== 1'b0 || cnt0_o !== 8'd0 || ready_o !== 1'b1) begin
      n_fails++;
      $display("FAIL async_reset got v=%b c=%0d r=%b exp 0 0 1",
               valid0_o, cnt0_o, ready_o);
    end
    q0.delete(); q1.delete(); acc0 = 0; acc1 = 0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    ready1_i = 1'b1; select_i = 1'b1; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = vals[i];
      tick();
      n_checks++;
      if (valid1_o !== 1'b1 || data1_o !== vals[i] || valid0_o !== 1'b0) begin
        n_fails++;
        $display("FAIL b2b_%0d got v1=%b d1=%h v0=%b exp 1 %h 0",
                 i, valid1_o, data1_o, valid0_o, vals[i]);
      end
    end
    valid_i = 1'b0;
    tick();
    n_checks++;
    if (valid1_o !== 1'b0 || cnt1_o !== 8'd3) begin
      n_fails++;
      $display("FAIL b2b_end got v1=%b c1=%0d exp 0 3", valid1_o, cnt1_o);
    end
  endtask

  task automatic test_backpressure();
    ready0_i = 1'b0; select_i = 1'b0; valid_i = 1'b1;
    data_i = 32'h11; tick();
    data_i = 32'h22; tick();
    data_i = 32'h33;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || data0_o !== 32'h11 || valid0_o !== 1'b1) begin
      n_fails++;
      $display("FAIL bp_stall got r=%b d0=%h exp 0 11", ready_o, data0_o);
    end
    select_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fails++;
      $display("FAIL bp_switch got r=%b exp 1", ready_o);
    end
    tick();
    valid_i = 1'b0;
    #1;
    n_checks++;
    if (valid1_o !== 1'b1 || data1_o !== 32'h33 || cnt1_o !== 8'd4) begin
      n_fails++;
      $display("FAIL bp_br1 got v1=%b d1=%h c1=%0d exp 1 33 4",
               valid1_o, data1_o, cnt1_o);
    end
    tick();
  endtask

  task automatic test_full_pop();
    select_i = 1'b0; valid_i = 1'b1; data_i = 32'h44; ready0_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || data0_o !== 32'h11) begin
      n_fails++;
      $display("FAIL fp_same got r=%b d0=%h exp 0 11", ready_o, data0_o);
    end
    tick();
    n_checks++;
    if (ready_o !== 1'b1 || data0_o !== 32'h22) begin
      n_fails++;
      $display("FAIL fp_next got r=%b d0=%h exp 1 22", ready_o, data0_o);
    end
    tick();
    valid_i = 1'b0;
    #1;
    n_checks++;
    if (valid0_o !== 1'b1 || data0_o !== 32'h44 || cnt0_o !== 8'd3) begin
      n_fails++;
      $display("FAIL fp_order got v0=%b d0=%h c0=%0d exp 1 44 3",
               valid0_o, data0_o, cnt0_o);
    end
    tick();
    n_checks++;
    if (valid0_o !== 1'b0) begin
      n_fails++;
      $display("FAIL fp_drain got v0=%b exp 0", valid0_o);
    end
  endtask

  task automatic test_counter_wrap();
    int errs;
    errs = 0;
    hw_reset();
    ready0_i = 1'b1; select_i = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      data_i = 32'h1000 + i;
      tick();
      if (cnt0_o !== 8'(i + 1) || valid0_o !== 1'b1 ||
          data0_o !== 32'h1000 + i) begin
        errs++;
        if (errs < 4)
          $display("FAIL wrap_%0d got c0=%0d d0=%h exp %0d %h",
                   i, cnt0_o, data0_o, 8'(i + 1), 32'h1000 + i);
      end
      if (i == 254) begin
        n_checks++;
        if (cnt0_o !== 8'd255) begin
          n_fails++;
          $display("FAIL wrap_255 got %0d exp 255", cnt0_o);
        end
      end
    end
    n_checks++;
    if (errs != 0) n_fails++;
    n_checks++;
    if (cnt0_o !== 8'd0) begin
      n_fails++;
      $display("FAIL wrap_zero got %0d exp 0", cnt0_o);
    end
    valid_i = 1'b0;
    tick();
    n_checks++;
    if (valid0_o !== 1'b0 || acc0 != 256) begin
      n_fails++;
      $display("FAIL wrap_loss got v0=%b acc=%0d exp 0 256", valid0_o, acc0);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 1000; c++) begin
      valid_i  = 1'($urandom_range(0, 1));
      select_i = 1'($urandom_range(0, 1));
      ready0_i = ($urandom_range(0, 3) != 0);
      ready1_i = ($urandom_range(0, 2) == 0);
      data_i   = $urandom;
      #1;
      if (ready_o !== (select_i ? (q1.size() < 2) : (q0.size() < 2)) ||
          valid0_o !== (q0.size() != 0) || valid1_o !== (q1.size() != 0) ||
          (q0.size() != 0 && data0_o !== q0[0]) ||
          (q1.size() != 0 && data1_o !== q1[0]) ||
          cnt0_o !== 8'(acc0) || cnt1_o !== 8'(acc1)) begin
        errs++;
        if (errs < 6)
          $display("FAIL rand_%0d got r=%b v=%b%b c=%0d/%0d exp q=%0d/%0d acc=%0d/%0d",
                   c, ready_o, valid0_o, valid1_o, cnt0_o, cnt1_o,
                   q0.size(), q1.size(), acc0 % 256, acc1 % 256);
      end
      tick();
    end
    n_checks++;
    if (errs != 0) begin
      n_fails++;
      $display("FAIL rand_total got %0d bad cycles exp 0", errs);
    end
  endtask

  initial begin
    n_checks = 0; n_fails = 0; acc0 = 0; acc1 = 0;
    rst_n = 1'b0; data_i = '0; select_i = 1'b0; valid_i = 1'b0;
    ready0_i = 1'b0; ready1_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_full_pop();
    test_counter_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
